cmp_share_arbiter: RTL and testbench
====================================

// Module: cmp_share_arbiter
// PURPOSE
//  Shares one combinational N-bit magnitude comparator among NREQ requesters.
//  Round-robin picks a requester, registers its operands onto the comparator inputs, captures the
//  greater/equal/lesser result and returns it with the requester ID over a valid/ready response port.
//  Sits between operand producers and the single comparator instance in the datapath.
// PARAMETERS
//  N     3  operand width in bits (>=1)
//  NREQ  4  number of requesters (>=1); IDW = max(1,$clog2(NREQ))
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   NREQ    per-requester operand pair valid
//  req_a        in   NREQ*N  operand A, requester i at [i*N +: N]
//  req_b        in   NREQ*N  operand B, requester i at [i*N +: N]
//  req_ready    out  NREQ    one-hot accept pulse; pair i taken when req_valid[i]&req_ready[i]
//  cmp_a        out  N       registered operand A to shared comparator
//  cmp_b        out  N       registered operand B to shared comparator
//  cmp_greater  in   1       comparator result a>b
//  cmp_equal    in   1       comparator result a==b
//  cmp_lesser   in   1       comparator result a<b
//  rsp_valid    out  1       response valid, held until rsp_ready
//  rsp_ready    in   1       response consumer ready
//  rsp_id       out  IDW     index of requester the result belongs to
//  rsp_greater  out  1       captured greater
//  rsp_equal    out  1       captured equal
//  rsp_lesser   out  1       captured lesser
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, cmp_a=cmp_b=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_* flags=0.
//  FSM IDLE->CMP->RESP->IDLE; one transaction in flight; min 3 cycles per transaction.
//  IDLE: if |req_valid, grant g = first i with req_valid[i] scanning ptr,ptr+1..NREQ-1,0..ptr-1;
//   req_ready = onehot(g) combinationally in IDLE only; at edge latch cmp_a/cmp_b<=req_a/b[g], id<=g, ->CMP.
//   No valid: stay IDLE, req_ready=0. Requester may drop valid before grant with no effect.
//  CMP: comparator settles on registered inputs; at edge rsp_*<=cmp_*, rsp_id<=id, rsp_valid<=1, ->RESP.
//  RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready: rsp_valid<=0,
//   ptr <= (id==NREQ-1)?0:id+1, ->IDLE. req_ready=0 throughout CMP and RESP.
//  rsp_ready high on the cycle rsp_valid rises: handshake completes on the next edge (1 cycle in RESP).
//  cmp_a/cmp_b hold last operands after a transaction (no return to 0).
//  NREQ=1: ptr stays 0, arbiter degenerates to a 3-cycle sequencer.
//  Fairness: with all requesters valid continuously, grants rotate 0,1,..,NREQ-1,0.
//  Reset asserted mid-transaction: in-flight transaction dropped, no response issued; restart at IDLE, ptr=0.
// CONFIGURATION
//  CMP_ONEHOT_CHECK_EN defined: extra output cmp_err (1 bit, reset 0); set in CMP when
//   {cmp_greater,cmp_equal,cmp_lesser} is not one-hot; sticky until reset; response still issued as captured.
//  Not defined: no cmp_err port, no check logic.
// STRUCTURE
//  Package cmp_arb_pkg: state enum {IDLE,CMP,RESP} (2-bit), IDW computation function.
//  Sub-module rr_pick (NREQ): inputs req vector and ptr, outputs grant one-hot, grant index, any.
//  Top holds FSM, operand/response registers and ptr.
// TESTING (N=3, NREQ=4, external comparator model attached)
//  Reset, req_valid=0 -> all outputs 0, state IDLE, no req_ready pulse for 10 cycles.
//  req_valid=4'b0001, a0=000,b0=111, rsp_ready=1 -> req_ready=0001 one cycle; 2 cycles later rsp_valid, id=0, L=1,G=0,E=0.
//  req_valid=4'b1111 held, pairs (001,000),(101,101),(011,100),(111,111) -> id order 0,1,2,3 with G,E,L,E.
//  rsp_ready=0 for 5 cycles in RESP, a1=010,b1=010 -> rsp_valid,id=1,E=1 stable 5 cycles; no new req_ready.
//  rst_n low during CMP of a pair -> no response; after release ptr=0, requester 0 granted first.
//  CMP_ONEHOT_CHECK_EN: model drives G=E=1 -> cmp_err=1 sticky across later good compares until reset.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// Shared definitions for the comparator-sharing arbiter: FSM state encoding and ID width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cmp_arb_pkg;

    // One transaction in flight: pick in IDLE, let the comparator settle in CMP, hold result in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requester ID width; a single requester still gets a 1-bit ID field.
    function automatic int calc_idw(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping past NREQ-1 back to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports:
//   req      in   NREQ   request vector
//   ptr      in   IDW    highest-priority index this cycle
//   gnt      out  NREQ   one-hot grant (all zero when no request)
//   gnt_idx  out  IDW    index of the granted requester (0 when no request)
//   any      out  1      at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    always_comb begin : scan
        logic           found;
        int             sum;
        logic [IDW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        // Walk the ring starting at ptr; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = IDW'(sum);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one external N-bit magnitude comparator among NREQ requesters, round-robin.
// Latency: grant cycle + 1 compare cycle, response valid 2 cycles after the accept pulse; >=3 cycles/txn.
// Backpressure: response held stable while rsp_ready=0; no new request accepted until it is consumed.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_a/req_b      per-requester operand pairs (requester i at [i*N +: N])
//   req_ready                  one-hot accept pulse, only ever high in IDLE
//   cmp_a/cmp_b                registered operands to the shared comparator (hold after a transaction)
//   cmp_greater/equal/lesser   comparator results, sampled at the end of the compare cycle
//   rsp_valid/rsp_ready        response handshake
//   rsp_id, rsp_greater/equal/lesser   captured requester ID and result
//   cmp_err                    (only with CMP_ONEHOT_CHECK_EN) sticky flag: result was not one-hot
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter  int N    = 3,
    parameter  int NREQ = 4,
    localparam int IDW  = calc_idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      cmp_a,
    output logic [N-1:0]      cmp_b,
    input  logic              cmp_greater,
    input  logic              cmp_equal,
    input  logic              cmp_lesser,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_greater,
    output logic              rsp_equal,
    output logic              rsp_lesser
`ifdef CMP_ONEHOT_CHECK_EN
    ,
    output logic              cmp_err
`endif
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // The accept pulse is the grant itself, so a requester that drops valid before
    // being picked simply never sees it.
    assign req_ready = (state == IDLE) ? gnt : '0;

`ifdef CMP_ONEHOT_CHECK_EN
    logic res_onehot;
    assign res_onehot = ( cmp_greater & ~cmp_equal & ~cmp_lesser) |
                        (~cmp_greater &  cmp_equal & ~cmp_lesser) |
                        (~cmp_greater & ~cmp_equal &  cmp_lesser);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_greater <= 1'b0;
            rsp_equal   <= 1'b0;
            rsp_lesser  <= 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
            cmp_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        cmp_a <= req_a[gnt_idx*N +: N];
                        cmp_b <= req_b[gnt_idx*N +: N];
                        id    <= gnt_idx;
                        state <= CMP;
                    end
                end
                CMP: begin
                    // Operands have been stable on the comparator for a full cycle.
                    rsp_greater <= cmp_greater;
                    rsp_equal   <= cmp_equal;
                    rsp_lesser  <= cmp_lesser;
                    rsp_id      <= id;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
`ifdef CMP_ONEHOT_CHECK_EN
                    if (!res_onehot) begin
                        cmp_err <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        // Priority moves to the requester just after the one served.
                        ptr       <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter (N=3, NREQ=4) with a behavioural comparator attached.
// A transaction-level model is checked every cycle; directed scenarios add literal expectations.
// Optional block CMP_ONEHOT_CHECK_EN exercises the sticky cmp_err flag.
module tb_cmp_share_arbiter;

    localparam int N    = 3;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      cmp_a;
    logic [N-1:0]      cmp_b;
    logic              cmp_greater;
    logic              cmp_equal;
    logic              cmp_lesser;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_greater;
    logic              rsp_equal;
    logic              rsp_lesser;
    logic              inject;
`ifdef CMP_ONEHOT_CHECK_EN
    logic              cmp_err;
`endif

    always #5 clk = ~clk;

    // Shared comparator; 'inject' forces an illegal G=E=1 result.
    assign cmp_greater = inject | (cmp_a > cmp_b);
    assign cmp_equal   = inject | (cmp_a == cmp_b);
    assign cmp_lesser  = ~inject & (cmp_a < cmp_b);

    cmp_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_greater (cmp_greater),
        .cmp_equal   (cmp_equal),
        .cmp_lesser  (cmp_lesser),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_greater (rsp_greater),
        .rsp_equal   (rsp_equal),
        .rsp_lesser  (rsp_lesser)
`ifdef CMP_ONEHOT_CHECK_EN
        ,
        .cmp_err     (cmp_err)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_grants = 0;
    int       log_id[$];
    logic [2:0] log_f[$];   // {greater, equal, lesser}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid requester scanning from p around the ring, or -1.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Transaction-level model: idle/waiting for grant, then one compare cycle, then the
    // response offered until consumed.
    logic       m_busy = 1'b0;
    int         m_age  = 0;
    int         m_ptr  = 0;
    int         m_id   = 0;
    logic [N-1:0] m_a  = '0;
    logic [N-1:0] m_b  = '0;
    logic [2:0] m_f    = '0;
    logic       m_err  = 1'b0;

    always @(negedge clk) begin : model
        int g;
        logic [NREQ-1:0] er;
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_ptr = 0; m_a = '0; m_b = '0; m_err = 1'b0;
        end
        g  = pick(req_valid, m_ptr);
        er = (!m_busy && g >= 0) ? NREQ'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (req_ready != '0) n_grants++;
        chk("cmp_a", 32'(cmp_a), 32'(m_a));
        chk("cmp_b", 32'(cmp_b), 32'(m_b));
`ifdef CMP_ONEHOT_CHECK_EN
        chk("cmp_err", 32'(cmp_err), 32'(m_err));
`endif
        if (!rst_n) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp", 32'({rsp_id, rsp_greater, rsp_equal, rsp_lesser}), 32'd0);
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age == 1));
            if (m_busy && m_age == 1) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_flags", 32'({rsp_greater, rsp_equal, rsp_lesser}), 32'(m_f));
            end
            if (rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_f.push_back({rsp_greater, rsp_equal, rsp_lesser});
            end
            // Advance to what the coming edge does.
            if (!m_busy) begin
                if (g >= 0) begin
                    m_a = req_a[g*N +: N];
                    m_b = req_b[g*N +: N];
                    m_id = g; m_busy = 1'b1; m_age = 0;
                end
            end else if (m_age == 0) begin
                if (inject) begin
                    m_f = 3'b110;
                    m_err = 1'b1;
                end else begin
                    m_f = {m_a > m_b, m_a == m_b, m_a < m_b};
                end
                m_age = 1;
            end else if (rsp_ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % NREQ;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    // Wait (bounded) until n_grants reaches target; returns just after the accepting edge.
    task automatic wait_grants(input int target, input string name);
        int t;
        t = 0;
        while (n_grants < target && t < 200) begin
            tick(1);
            t++;
        end
        chk({name, "_grant_timeout"}, 32'(n_grants >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g0;
        int l0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; inject = 1'b0;

        // Reset and idle: nothing offered, nothing granted.
        tick(2);
        do_reset();
        tick(10);
        chk("idle_grants", 32'(n_grants), 32'd0);
        chk("idle_rsps", 32'(log_id.size()), 32'd0);
        chk("idle_outputs", 32'({cmp_a, cmp_b, rsp_valid, rsp_id}), 32'd0);

        // Single request: 000 vs 111 -> lesser, id 0.
        rsp_ready = 1'b1;
        set_pair(0, 3'b000, 3'b111);
        req_valid = 4'b0001;
        wait_grants(1, "single");
        req_valid = '0;
        tick(6);
        chk("single_grants", 32'(n_grants), 32'd1);
        chk("single_nrsp", 32'(log_id.size()), 32'd1);
        if (log_id.size() == 1) begin
            chk("single_id", 32'(log_id[0]), 32'd0);
            chk("single_flags", 32'(log_f[0]), 32'b001);
        end

        // Fairness: all four held, rotate 0,1,2,3 with G,E,L,E.
        do_reset();
        log_id.delete(); log_f.delete();
        g0 = n_grants;
        set_pair(0, 3'b001, 3'b000);
        set_pair(1, 3'b101, 3'b101);
        set_pair(2, 3'b011, 3'b100);
        set_pair(3, 3'b111, 3'b111);
        req_valid = 4'b1111;
        wait_grants(g0 + 4, "rr");
        req_valid = '0;
        tick(6);
        chk("rr_nrsp", 32'(log_id.size()), 32'd4);
        if (log_id.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_id", 32'(log_id[i]), 32'(i));
            chk("rr_f0", 32'(log_f[0]), 32'b100);
            chk("rr_f1", 32'(log_f[1]), 32'b010);
            chk("rr_f2", 32'(log_f[2]), 32'b001);
            chk("rr_f3", 32'(log_f[3]), 32'b010);
        end

        // Backpressure: response held 5 cycles, no new accept while held.
        rsp_ready = 1'b0;
        set_pair(1, 3'b010, 3'b010);
        req_valid = 4'b0010;
        g0 = n_grants;
        wait_grants(g0 + 1, "bp");
        req_valid = 4'b1111;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_equal", 32'(rsp_equal), 32'd1);
        end
        chk("bp_no_grant", 32'(n_grants), 32'(g0 + 1));
        req_valid = '0;
        tick(1);
        rsp_ready = 1'b1;
        tick(4);

        // Reset during the compare cycle: response dropped, priority back to 0.
        l0 = log_id.size();
        set_pair(2, 3'b110, 3'b001);
        req_valid = 4'b0100;
        g0 = n_grants;
        wait_grants(g0 + 1, "rst_mid");
        req_valid = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("rst_mid_nrsp", 32'(log_id.size()), 32'(l0));
        set_pair(0, 3'b011, 3'b011);
        set_pair(3, 3'b001, 3'b010);
        req_valid = 4'b1001;
        g0 = n_grants;
        wait_grants(g0 + 1, "rst_first");
        req_valid = '0;
        tick(5);
        chk("rst_first_nrsp", 32'(log_id.size()), 32'(l0 + 1));
        if (log_id.size() == l0 + 1) chk("rst_first_id", 32'(log_id[l0]), 32'd0);

`ifdef CMP_ONEHOT_CHECK_EN
        // Illegal comparator result sets cmp_err; it survives later good compares.
        chk("err_pre", 32'(cmp_err), 32'd0);
        inject = 1'b1;
        req_valid = 4'b0010;
        g0 = n_grants;
        wait_grants(g0 + 1, "err");
        req_valid = '0;
        tick(4);
        inject = 1'b0;
        chk("err_set", 32'(cmp_err), 32'd1);
        chk("err_flags", 32'(log_f[log_f.size()-1]), 32'b110);
        req_valid = 4'b0001;
        g0 = n_grants;
        wait_grants(g0 + 1, "err_good");
        req_valid = '0;
        tick(5);
        chk("err_sticky", 32'(cmp_err), 32'd1);
        do_reset();
        tick(1);
        chk("err_clear", 32'(cmp_err), 32'd0);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
